slowram_arbiter: RTL and testbench

- Shares the single-port 128 KiB slow RAM (banks E0/E1) between CPU accesses and video fetches.
- CPU accesses align to the 1 MHz slot strobe; while pending they stall the core through cpu_wait.
- Video fetches are granted on any idle cycle, with a starvation guard that protects CPU accesses.
- Sits between the core/shadow decode and the slow RAM macro, replacing the direct chip-enable drive.

---
 rtl/slowram_arbiter_if.sv | 47 ++++
 rtl/slowram_arbiter.sv | 154 +++++++++++++++
 tb/tb_slowram_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/slowram_arbiter_if.sv
// slowram_arbiter_if
// Bundles the three buses around the slow RAM arbiter:
//   CPU side   : cpu_req, cpu_we, cpu_addr, cpu_din -> cpu_dout, cpu_ack, cpu_wait
//   Video side : vid_req, vid_addr                  -> vid_dout, vid_ack
//   RAM side   : ram_ce, ram_we, ram_addr, ram_din  <- ram_dout
// The arbiter connects through the slave modport. The surrounding system
// (core, video fetch and RAM macro) connects through the master modport.
interface slowram_arbiter_if #(
  parameter int RAM_AW = 17
);
  logic              cpu_req;
  logic              cpu_we;
  logic [RAM_AW-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_ack;
  logic              cpu_wait;

  logic              vid_req;
  logic [RAM_AW-1:0] vid_addr;
  logic [7:0]        vid_dout;
  logic              vid_ack;

  logic              ram_ce;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack, cpu_wait,
    input  vid_req, vid_addr,
    output vid_dout, vid_ack,
    output ram_ce, ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack, cpu_wait,
    output vid_req, vid_addr,
    input  vid_dout, vid_ack,
    input  ram_ce, ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/slowram_arbiter.sv
// slowram_arbiter
// Shares the single-port 128 KiB slow RAM between CPU accesses and video
// fetches. CPU accesses start only on the 1 MHz slot strobe and stall the
// core through cpu_wait; video fetches take any idle cycle, limited by a
// starvation guard so a waiting CPU access is granted after MAX_VID fetches.
// Ports:
//   clk_sys   system clock
//   reset     synchronous, active-high reset
//   slow_tick one-cycle slot strobe qualifying CPU access starts
//   bus       slowram_arbiter_if.slave (CPU, video and RAM buses)
module slowram_arbiter #(
  parameter int RAM_AW  = 17,
  parameter int RAM_LAT = 1,
  parameter int MAX_VID = 4
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 slow_tick,
  slowram_arbiter_if.slave     bus
);

  localparam int VW = $clog2(MAX_VID + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAITD, DONE} state_t;

  state_t            state_q, state_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic              gcpu_q, gcpu_d;
  logic              wr_q, wr_d;

  logic              ram_ce_q, ram_ce_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic [7:0]        vid_dout_q, vid_dout_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_ack_q, vid_ack_d;

  // A requester whose ack is showing this cycle has not yet had the chance
  // to drop its request, so it is not treated as a new request.
  logic cpu_pend, vid_pend, vcnt_max;
  assign cpu_pend = bus.cpu_req & ~cpu_ack_q;
  assign vid_pend = bus.vid_req & ~vid_ack_q;
  assign vcnt_max = (vcnt_q == VW'(MAX_VID));

  always_comb begin
    state_d    = state_q;
    vcnt_d     = vcnt_q;
    wcnt_d     = wcnt_q;
    gcpu_d     = gcpu_q;
    wr_d       = wr_q;
    ram_ce_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    cpu_dout_d = cpu_dout_q;
    vid_dout_d = vid_dout_q;
    cpu_ack_d  = 1'b0;
    vid_ack_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_pend && slow_tick && (vcnt_max || !vid_pend)) begin
          state_d    = ISSUE;
          ram_ce_d   = 1'b1;
          ram_we_d   = bus.cpu_we;
          ram_addr_d = bus.cpu_addr;
          ram_din_d  = bus.cpu_din;
          gcpu_d     = 1'b1;
          wr_d       = bus.cpu_we;
          vcnt_d     = '0;
        end else if (vid_pend && !(vcnt_max && cpu_pend)) begin
          // Once the guard count is reached, video stays blocked until
          // the waiting CPU access has been granted on a later tick.
          state_d    = ISSUE;
          ram_ce_d   = 1'b1;
          ram_addr_d = bus.vid_addr;
          gcpu_d     = 1'b0;
          wr_d       = 1'b0;
          if (!cpu_pend)      vcnt_d = '0;
          else if (!vcnt_max) vcnt_d = vcnt_q + 1'b1;
        end
      end
      ISSUE: begin
        if (RAM_LAT > 1) begin
          state_d = WAITD;
          wcnt_d  = 2'(RAM_LAT - 2);
        end else begin
          state_d = DONE;
        end
      end
      WAITD: begin
        if (wcnt_q == 2'd0) state_d = DONE;
        else                wcnt_d  = wcnt_q - 2'd1;
      end
      DONE: begin
        // ram_dout is valid during DONE; data and ack appear together.
        if (!wr_q) begin
          if (gcpu_q) cpu_dout_d = bus.ram_dout;
          else        vid_dout_d = bus.ram_dout;
        end
        if (gcpu_q) cpu_ack_d = 1'b1;
        else        vid_ack_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      vcnt_q     <= '0;
      wcnt_q     <= '0;
      gcpu_q     <= 1'b0;
      wr_q       <= 1'b0;
      ram_ce_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      cpu_dout_q <= '0;
      vid_dout_q <= '0;
      cpu_ack_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vcnt_q     <= vcnt_d;
      wcnt_q     <= wcnt_d;
      gcpu_q     <= gcpu_d;
      wr_q       <= wr_d;
      ram_ce_q   <= ram_ce_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      cpu_dout_q <= cpu_dout_d;
      vid_dout_q <= vid_dout_d;
      cpu_ack_q  <= cpu_ack_d;
      vid_ack_q  <= vid_ack_d;
    end
  end

  assign bus.ram_ce   = ram_ce_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.vid_dout = vid_dout_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.vid_ack  = vid_ack_q;
  assign bus.cpu_wait = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_slowram_arbiter.sv
// Testbench for slowram_arbiter: instance A uses RAM_LAT=1, instance B uses
// RAM_LAT=3. Each has its own behavioural RAM model.
module tb_slowram_arbiter;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic rst_a, rst_b, tick_a, tick_b;
  int   vecs = 0;
  int   errs = 0;

  slowram_arbiter_if #(.RAM_AW(17)) bus_a ();
  slowram_arbiter_if #(.RAM_AW(17)) bus_b ();

  slowram_arbiter #(.RAM_AW(17), .RAM_LAT(1), .MAX_VID(4)) u_dut_a (
    .clk_sys(clk_sys), .reset(rst_a), .slow_tick(tick_a), .bus(bus_a.slave));

  slowram_arbiter #(.RAM_AW(17), .RAM_LAT(3), .MAX_VID(4)) u_dut_b (
    .clk_sys(clk_sys), .reset(rst_b), .slow_tick(tick_b), .bus(bus_b.slave));

  // RAM models: synchronous, read data RAM_LAT cycles after the ce edge.
  logic [7:0]  mem_a [0:131071];
  logic [7:0]  mem_b [0:131071];
  logic [7:0]  rd_a, rb0, rb1, rb2;
  logic        init_a, init_b;
  logic [16:0] init_addr;
  logic [7:0]  init_data;

  always @(posedge clk_sys) begin
    if (init_a) mem_a[init_addr] <= init_data;
    else if (bus_a.ram_ce) begin
      if (bus_a.ram_we) mem_a[bus_a.ram_addr] <= bus_a.ram_din;
      rd_a <= mem_a[bus_a.ram_addr];
    end
  end
  assign bus_a.ram_dout = rd_a;

  always @(posedge clk_sys) begin
    if (init_b) mem_b[init_addr] <= init_data;
    else if (bus_b.ram_ce) begin
      if (bus_b.ram_we) mem_b[bus_b.ram_addr] <= bus_b.ram_din;
      rb0 <= mem_b[bus_b.ram_addr];
    end
    rb1 <= rb0;
    rb2 <= rb1;
  end
  assign bus_b.ram_dout = rb2;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.cpu_req = 0; bus_a.cpu_we = 0; bus_a.cpu_addr = '0; bus_a.cpu_din = '0;
    bus_a.vid_req = 0; bus_a.vid_addr = '0;
    bus_b.cpu_req = 0; bus_b.cpu_we = 0; bus_b.cpu_addr = '0; bus_b.cpu_din = '0;
    bus_b.vid_req = 0; bus_b.vid_addr = '0;
    tick_a = 0; tick_b = 0;
  endtask

  task automatic poke(input logic sel_b, input logic [16:0] a, input logic [7:0] d);
    init_addr = a; init_data = d;
    if (sel_b) init_b = 1; else init_a = 1;
    step();
    init_a = 0; init_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_a = 1; rst_b = 1;
    step(); step();
    rst_a = 0; rst_b = 0;
  endtask

  task automatic test_reset();
    // Requests held during reset must not leak through.
    rst_a = 1; rst_b = 1;
    bus_a.cpu_req = 1; bus_a.vid_req = 1; bus_a.cpu_addr = 17'h1ABCD; bus_a.cpu_din = 8'hFF;
    tick_a = 1;
    step(); step();
    vecs++; if (bus_a.ram_ce   !== 1'b0)   begin errs++; $display("FAIL rst_ram_ce got=%0h exp=0", bus_a.ram_ce); end
    vecs++; if (bus_a.ram_we   !== 1'b0)   begin errs++; $display("FAIL rst_ram_we got=%0h exp=0", bus_a.ram_we); end
    vecs++; if (bus_a.ram_addr !== 17'h0)  begin errs++; $display("FAIL rst_ram_addr got=%0h exp=0", bus_a.ram_addr); end
    vecs++; if (bus_a.ram_din  !== 8'h0)   begin errs++; $display("FAIL rst_ram_din got=%0h exp=0", bus_a.ram_din); end
    vecs++; if (bus_a.cpu_dout !== 8'h0)   begin errs++; $display("FAIL rst_cpu_dout got=%0h exp=0", bus_a.cpu_dout); end
    vecs++; if (bus_a.vid_dout !== 8'h0)   begin errs++; $display("FAIL rst_vid_dout got=%0h exp=0", bus_a.vid_dout); end
    vecs++; if (bus_a.cpu_ack  !== 1'b0)   begin errs++; $display("FAIL rst_cpu_ack got=%0h exp=0", bus_a.cpu_ack); end
    vecs++; if (bus_a.vid_ack  !== 1'b0)   begin errs++; $display("FAIL rst_vid_ack got=%0h exp=0", bus_a.vid_ack); end
    idle_inputs();
    poke(1'b0, 17'h12000, 8'hA5);
    poke(1'b1, 17'h12000, 8'h5A);
    rst_a = 0; rst_b = 0;
    step();
  endtask

  task automatic test_vid_read();
    bus_a.vid_addr = 17'h12000; bus_a.vid_req = 1;
    step();
    vecs++; if (bus_a.ram_ce !== 1'b1) begin errs++; $display("FAIL vid_ce got=%0h exp=1", bus_a.ram_ce); end
    vecs++; if (bus_a.ram_we !== 1'b0) begin errs++; $display("FAIL vid_we got=%0h exp=0", bus_a.ram_we); end
    vecs++; if (bus_a.ram_addr !== 17'h12000) begin errs++; $display("FAIL vid_addr got=%0h exp=12000", bus_a.ram_addr); end
    step();
    vecs++; if (bus_a.vid_ack !== 1'b0) begin errs++; $display("FAIL vid_ack_early got=%0h exp=0", bus_a.vid_ack); end
    vecs++; if (bus_a.ram_ce !== 1'b0) begin errs++; $display("FAIL vid_ce_once got=%0h exp=0", bus_a.ram_ce); end
    step();
    vecs++; if (bus_a.vid_ack !== 1'b1) begin errs++; $display("FAIL vid_ack got=%0h exp=1", bus_a.vid_ack); end
    vecs++; if (bus_a.vid_dout !== 8'hA5) begin errs++; $display("FAIL vid_dout got=%0h exp=a5", bus_a.vid_dout); end
    bus_a.vid_req = 0;
    step();
    vecs++; if (bus_a.vid_ack !== 1'b0) begin errs++; $display("FAIL vid_ack_pulse got=%0h exp=0", bus_a.vid_ack); end
    vecs++; if (bus_a.vid_dout !== 8'hA5) begin errs++; $display("FAIL vid_dout_hold got=%0h exp=a5", bus_a.vid_dout); end
  endtask

  task automatic test_cpu_write();
    bus_a.cpu_req = 1; bus_a.cpu_we = 1; bus_a.cpu_addr = 17'h00400; bus_a.cpu_din = 8'h3C;
    for (int i = 1; i <= 5; i++) begin
      step();
      vecs++; if (bus_a.cpu_wait !== 1'b1) begin errs++; $display("FAIL wr_wait_pre%0d got=%0h exp=1", i, bus_a.cpu_wait); end
      vecs++; if (bus_a.ram_ce !== 1'b0) begin errs++; $display("FAIL wr_ce_pre%0d got=%0h exp=0", i, bus_a.ram_ce); end
    end
    tick_a = 1;
    step();
    tick_a = 0;
    vecs++; if (bus_a.ram_ce !== 1'b1) begin errs++; $display("FAIL wr_ce got=%0h exp=1", bus_a.ram_ce); end
    vecs++; if (bus_a.ram_we !== 1'b1) begin errs++; $display("FAIL wr_we got=%0h exp=1", bus_a.ram_we); end
    vecs++; if (bus_a.ram_addr !== 17'h00400) begin errs++; $display("FAIL wr_addr got=%0h exp=400", bus_a.ram_addr); end
    vecs++; if (bus_a.ram_din !== 8'h3C) begin errs++; $display("FAIL wr_din got=%0h exp=3c", bus_a.ram_din); end
    step();
    vecs++; if (bus_a.ram_we !== 1'b0) begin errs++; $display("FAIL wr_we_once got=%0h exp=0", bus_a.ram_we); end
    vecs++; if (bus_a.cpu_wait !== 1'b1) begin errs++; $display("FAIL wr_wait_mid got=%0h exp=1", bus_a.cpu_wait); end
    step();
    vecs++; if (bus_a.cpu_ack !== 1'b1) begin errs++; $display("FAIL wr_ack got=%0h exp=1", bus_a.cpu_ack); end
    vecs++; if (bus_a.cpu_wait !== 1'b0) begin errs++; $display("FAIL wr_wait_ack got=%0h exp=0", bus_a.cpu_wait); end
    vecs++; if (bus_a.cpu_dout !== 8'h00) begin errs++; $display("FAIL wr_dout_kept got=%0h exp=0", bus_a.cpu_dout); end
    bus_a.cpu_req = 0; bus_a.cpu_we = 0;
    step();
    vecs++; if (bus_a.cpu_ack !== 1'b0) begin errs++; $display("FAIL wr_ack_pulse got=%0h exp=0", bus_a.cpu_ack); end
    vecs++; if (mem_a[17'h00400] !== 8'h3C) begin errs++; $display("FAIL wr_mem got=%0h exp=3c", mem_a[17'h00400]); end
  endtask

  task automatic test_cpu_read();
    bus_a.cpu_req = 1; bus_a.cpu_we = 0; bus_a.cpu_addr = 17'h00400; tick_a = 1;
    step();
    tick_a = 0;
    vecs++; if (bus_a.ram_ce !== 1'b1 || bus_a.ram_we !== 1'b0) begin errs++; $display("FAIL rd_ce got=%0h/%0h exp=1/0", bus_a.ram_ce, bus_a.ram_we); end
    step();
    vecs++; if (bus_a.cpu_ack !== 1'b0) begin errs++; $display("FAIL rd_ack_early got=%0h exp=0", bus_a.cpu_ack); end
    step();
    vecs++; if (bus_a.cpu_ack !== 1'b1) begin errs++; $display("FAIL rd_ack got=%0h exp=1", bus_a.cpu_ack); end
    vecs++; if (bus_a.cpu_dout !== 8'h3C) begin errs++; $display("FAIL rd_dout got=%0h exp=3c", bus_a.cpu_dout); end
    bus_a.cpu_req = 0;
    step();
  endtask

  task automatic test_addr_wrap();
    bus_a.cpu_req = 1; bus_a.cpu_we = 1; bus_a.cpu_addr = 17'h1FFFF; bus_a.cpu_din = 8'h77; tick_a = 1;
    step();
    tick_a = 0;
    vecs++; if (bus_a.ram_addr !== 17'h1FFFF) begin errs++; $display("FAIL wrap_addr got=%0h exp=1ffff", bus_a.ram_addr); end
    step(); step();
    bus_a.cpu_req = 0; bus_a.cpu_we = 0;
    bus_a.vid_req = 1; bus_a.vid_addr = 17'h1FFFF;
    step(); step(); step();
    vecs++; if (bus_a.vid_ack !== 1'b1 || bus_a.vid_dout !== 8'h77) begin errs++; $display("FAIL wrap_rd got=%0h/%0h exp=1/77", bus_a.vid_ack, bus_a.vid_dout); end
    bus_a.vid_req = 0;
    step();
  endtask

  task automatic test_simultaneous();
    int vid_k, cpu_k, ack_k, vack_k, ovl;
    logic prev_ce;
    vid_k = -1; cpu_k = -1; ack_k = -1; vack_k = -1; ovl = 0; prev_ce = 0;
    do_reset();
    bus_a.cpu_req = 1; bus_a.cpu_we = 0; bus_a.cpu_addr = 17'h00400;
    bus_a.vid_req = 1; bus_a.vid_addr = 17'h12000; tick_a = 1;
    for (int k = 1; k <= 14; k++) begin
      step();
      tick_a = (k == 8);
      if (bus_a.ram_ce && prev_ce) ovl++;
      prev_ce = bus_a.ram_ce;
      if (bus_a.ram_ce && bus_a.ram_addr == 17'h12000 && vid_k < 0) vid_k = k;
      if (bus_a.ram_ce && bus_a.ram_addr == 17'h00400 && cpu_k < 0) cpu_k = k;
      if (bus_a.vid_ack) begin vack_k = k; bus_a.vid_req = 0; end
      if (bus_a.cpu_ack) begin
        ack_k = k; bus_a.cpu_req = 0;
        vecs++; if (bus_a.cpu_dout !== 8'h3C) begin errs++; $display("FAIL sim_cpu_dout got=%0h exp=3c", bus_a.cpu_dout); end
      end
    end
    vecs++; if (vid_k !== 1)  begin errs++; $display("FAIL sim_vid_grant cycle got=%0d exp=1", vid_k); end
    vecs++; if (vack_k !== 3) begin errs++; $display("FAIL sim_vid_ack cycle got=%0d exp=3", vack_k); end
    vecs++; if (cpu_k !== 9)  begin errs++; $display("FAIL sim_cpu_grant cycle got=%0d exp=9", cpu_k); end
    vecs++; if (ack_k !== 11) begin errs++; $display("FAIL sim_cpu_ack cycle got=%0d exp=11", ack_k); end
    vecs++; if (ovl !== 0)    begin errs++; $display("FAIL sim_overlap got=%0d exp=0", ovl); end
  endtask

  task automatic test_starvation();
    int nvid, cpu_k, ovl;
    logic prev_ce;
    logic [2:0] vcnt_seen;
    nvid = 0; cpu_k = -1; ovl = 0; prev_ce = 0; vcnt_seen = 3'h7;
    do_reset();
    bus_a.cpu_req = 1; bus_a.cpu_we = 0; bus_a.cpu_addr = 17'h00400;
    bus_a.vid_req = 1; bus_a.vid_addr = 17'h12000; tick_a = 1;
    for (int k = 1; k <= 30; k++) begin
      step();
      tick_a = (k == 20);
      if (bus_a.ram_ce && prev_ce) ovl++;
      prev_ce = bus_a.ram_ce;
      if (bus_a.ram_ce && bus_a.ram_addr == 17'h12000 && cpu_k < 0) nvid++;
      if (bus_a.ram_ce && bus_a.ram_addr == 17'h00400 && cpu_k < 0) begin
        cpu_k = k; vcnt_seen = u_dut_a.vcnt_q;
      end
      if (bus_a.cpu_ack) bus_a.cpu_req = 0;
    end
    vecs++; if (nvid !== 4)          begin errs++; $display("FAIL starve_vid_grants got=%0d exp=4", nvid); end
    vecs++; if (cpu_k !== 21)        begin errs++; $display("FAIL starve_cpu_grant cycle got=%0d exp=21", cpu_k); end
    vecs++; if (vcnt_seen !== 3'd0)  begin errs++; $display("FAIL starve_vcnt_clear got=%0d exp=0", vcnt_seen); end
    vecs++; if (ovl !== 0)           begin errs++; $display("FAIL starve_overlap got=%0d exp=0", ovl); end
    vecs++; if (bus_a.ram_we !== 1'b0 && bus_a.ram_ce === 1'b1) begin errs++; $display("FAIL starve_vid_we got=%0h exp=0", bus_a.ram_we); end
  endtask

  task automatic test_reset_mid();
    int nack;
    nack = 0;
    do_reset();
    bus_b.vid_req = 1; bus_b.vid_addr = 17'h12000;
    step();
    vecs++; if (bus_b.ram_ce !== 1'b1) begin errs++; $display("FAIL rmid_ce got=%0h exp=1", bus_b.ram_ce); end
    step();
    rst_b = 1; bus_b.vid_req = 0;
    step();
    rst_b = 0;
    vecs++; if (bus_b.ram_ce !== 1'b0 || bus_b.ram_addr !== 17'h0) begin errs++; $display("FAIL rmid_ram got=%0h/%0h exp=0/0", bus_b.ram_ce, bus_b.ram_addr); end
    vecs++; if (bus_b.vid_ack !== 1'b0 || bus_b.vid_dout !== 8'h0) begin errs++; $display("FAIL rmid_vid got=%0h/%0h exp=0/0", bus_b.vid_ack, bus_b.vid_dout); end
    vecs++; if (bus_b.cpu_ack !== 1'b0 || bus_b.cpu_dout !== 8'h0) begin errs++; $display("FAIL rmid_cpu got=%0h/%0h exp=0/0", bus_b.cpu_ack, bus_b.cpu_dout); end
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus_b.vid_ack) nack++;
    end
    vecs++; if (nack !== 0) begin errs++; $display("FAIL rmid_no_ack got=%0d exp=0", nack); end
  endtask

  task automatic test_lat3();
    int ack_k, nce;
    logic [7:0] dout;
    ack_k = -1; nce = 0; dout = 8'h00;
    bus_b.vid_req = 1; bus_b.vid_addr = 17'h12000;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (bus_b.ram_ce) nce++;
      if (bus_b.vid_ack) begin ack_k = k; dout = bus_b.vid_dout; bus_b.vid_req = 0; end
    end
    vecs++; if (ack_k !== 5)    begin errs++; $display("FAIL lat3_ack cycle got=%0d exp=5", ack_k); end
    vecs++; if (dout !== 8'h5A) begin errs++; $display("FAIL lat3_dout got=%0h exp=5a", dout); end
    vecs++; if (nce !== 1)      begin errs++; $display("FAIL lat3_ce_count got=%0d exp=1", nce); end
  endtask

  initial begin
    init_a = 0; init_b = 0; init_addr = '0; init_data = '0;
    rst_a = 1; rst_b = 1;
    idle_inputs();
    test_reset();
    test_vid_read();
    test_cpu_write();
    test_cpu_read();
    test_addr_wrap();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
